// File: rtl/lc3_memio_pkg.sv
// Shared definitions for the LC-3 memory/IO access unit: FSM encodings,
// IO register offsets and the IO page decode helper.
package lc3_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [8:0] KBSR_OFS = 9'h000;
   localparam logic [8:0] KBDR_OFS = 9'h002;
   localparam logic [8:0] DSR_OFS  = 9'h004;
   localparam logic [8:0] DDR_OFS  = 9'h006;

   // Callers zero-extend both operands, so the upper bits always agree.
   function automatic logic is_io_page(input logic [31:0] addr, input logic [31:0] base);
      return (addr[31:9] == base[31:9]);
   endfunction

endpackage

// File: rtl/lc3_memio_if.sv
// CPU-side memory port of the LC-3 datapath: request/ready handshake,
// address, write data and held read data.
interface lc3_memio_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;

   modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                   input  cpu_rdata, cpu_ready);
   modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                   output cpu_rdata, cpu_ready);
endinterface

// File: rtl/lc3_mmio_regs.sv
// Keyboard and display device registers with their read mux; updated on
// the single-cycle IO strobe issued by the access FSM.
module lc3_mmio_regs
   import lc3_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              io_stb_i,
   input  logic              io_we_i,
   input  logic [8:0]        io_ofs_i,
   input  logic [7:0]        io_wdata_i,
   output logic [DATA_W-1:0] io_rdata_o,
   input  logic              kb_valid_i,
   input  logic [7:0]        kb_data_i,
   output logic              kb_ready_o,
   output logic              dsp_valid_o,
   output logic [7:0]        dsp_data_o,
   input  logic              dsp_ready_i
);
   logic       kb_full_q, kb_full_d;
   logic [7:0] kb_byte_q, kb_byte_d;
   logic       dsp_valid_q, dsp_valid_d;
   logic [7:0] dsp_data_q, dsp_data_d;
   logic       kbdr_rd_s, ddr_wr_s;

   assign kbdr_rd_s = io_stb_i & ~io_we_i & (io_ofs_i == KBDR_OFS);
   assign ddr_wr_s  = io_stb_i &  io_we_i & (io_ofs_i == DDR_OFS);

   // A keyboard capture on the same edge as a KBDR read wins over the clear.
   always_comb begin
      kb_full_d   = kb_full_q;
      kb_byte_d   = kb_byte_q;
      dsp_valid_d = dsp_valid_q;
      dsp_data_d  = dsp_data_q;
      if (kbdr_rd_s) kb_full_d = 1'b0;
      else           kb_full_d = kb_full_q;
      if (kb_valid_i && !kb_full_q) begin
         kb_full_d = 1'b1;
         kb_byte_d = kb_data_i;
      end else begin
         kb_byte_d = kb_byte_q;
      end
      if (dsp_valid_q && dsp_ready_i) dsp_valid_d = 1'b0;
      else                            dsp_valid_d = dsp_valid_q;
      if (ddr_wr_s && (!dsp_valid_q || dsp_ready_i)) begin
         dsp_valid_d = 1'b1;
         dsp_data_d  = io_wdata_i;
      end else begin
         dsp_data_d  = dsp_data_q;
      end
   end

   always_comb begin
      io_rdata_o = {DATA_W{1'b0}};
      case (io_ofs_i)
         KBSR_OFS: io_rdata_o = {kb_full_q, {(DATA_W-1){1'b0}}};
         KBDR_OFS: io_rdata_o = DATA_W'(kb_byte_q);
         DSR_OFS:  io_rdata_o = {~dsp_valid_q, {(DATA_W-1){1'b0}}};
         default:  io_rdata_o = {DATA_W{1'b0}};
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         kb_full_q   <= 1'b0;
         kb_byte_q   <= 8'h00;
         dsp_valid_q <= 1'b0;
         dsp_data_q  <= 8'h00;
      end else begin
         kb_full_q   <= kb_full_d;
         kb_byte_q   <= kb_byte_d;
         dsp_valid_q <= dsp_valid_d;
         dsp_data_q  <= dsp_data_d;
      end
   end

   assign kb_ready_o  = ~kb_full_q;
   assign dsp_valid_o = dsp_valid_q;
   assign dsp_data_o  = dsp_data_q;

endmodule

// File: rtl/lc3_memio.sv
// LC-3 memory/IO access unit: sequences wait-stated synchronous RAM accesses,
// routes the IO page to the device registers and issues the ready pulse.
module lc3_memio
   import lc3_pkg::*;
#(
   parameter int                DATA_W      = 16,
   parameter int                ADDR_W      = 16,
   parameter int                WAIT_STATES = 1,
   parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(16'hFE00)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   lc3_memio_if.slave        cpu,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_din_o,
   input  logic [DATA_W-1:0] mem_dout_i,
   input  logic              kb_valid_i,
   input  logic [7:0]        kb_data_i,
   output logic              kb_ready_o,
   output logic              dsp_valid_o,
   output logic [7:0]        dsp_data_o,
   input  logic              dsp_ready_i
);
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic              latch_s, io_hit_s, io_stb_s;
   logic [DATA_W-1:0] io_rdata_s;

   assign io_hit_s = is_io_page(32'(cpu.cpu_addr), 32'(IO_BASE));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      ready_d  = 1'b0;
      mem_en_d = mem_en_q;
      mem_we_d = 1'b0;
      latch_s  = 1'b0;
      io_stb_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu.cpu_req) begin
               latch_s = 1'b1;
               if (io_hit_s) begin
                  io_stb_s = 1'b1;
                  state_d  = ST_DONE;
                  ready_d  = 1'b1;
                  if (!cpu.cpu_we) rdata_d = io_rdata_s;
                  else             rdata_d = rdata_q;
               end else begin
                  state_d  = ST_ACCESS;
                  cnt_d    = CNT_INIT;
                  mem_en_d = 1'b1;
                  mem_we_d = cpu.cpu_we & (WAIT_STATES == 0);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         // The write strobe is registered one cycle ahead so it lands on the last ACCESS cycle.
         ST_ACCESS: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d  = ST_DONE;
               ready_d  = 1'b1;
               mem_en_d = 1'b0;
               if (!we_q) rdata_d = mem_dout_i;
               else       rdata_d = rdata_q;
            end else begin
               cnt_d    = cnt_q - CNT_W'(1);
               mem_we_d = we_q & (cnt_q == CNT_W'(1));
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         we_q     <= 1'b0;
         addr_q   <= {ADDR_W{1'b0}};
         wdata_q  <= {DATA_W{1'b0}};
         rdata_q  <= {DATA_W{1'b0}};
         ready_q  <= 1'b0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         mem_en_q <= mem_en_d;
         mem_we_q <= mem_we_d;
         if (latch_s) begin
            we_q    <= cpu.cpu_we;
            addr_q  <= cpu.cpu_addr;
            wdata_q <= cpu.cpu_wdata;
         end
      end
   end

   lc3_mmio_regs #(.DATA_W(DATA_W)) u_regs (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .io_stb_i    (io_stb_s),
      .io_we_i     (cpu.cpu_we),
      .io_ofs_i    (cpu.cpu_addr[8:0]),
      .io_wdata_i  (cpu.cpu_wdata[7:0]),
      .io_rdata_o  (io_rdata_s),
      .kb_valid_i  (kb_valid_i),
      .kb_data_i   (kb_data_i),
      .kb_ready_o  (kb_ready_o),
      .dsp_valid_o (dsp_valid_o),
      .dsp_data_o  (dsp_data_o),
      .dsp_ready_i (dsp_ready_i)
   );

   assign cpu.cpu_ready = ready_q;
   assign cpu.cpu_rdata = rdata_q;
   assign mem_en_o      = mem_en_q;
   assign mem_we_o      = mem_we_q;
   assign mem_addr_o    = addr_q;
   assign mem_din_o     = wdata_q;

endmodule

// File: tb/tb_lc3_memio.sv
// Bench for lc3_memio: three instances (0, 1 and 3 wait states) share one
// CPU driver; a scoreboard holds expected read data until each ready pulse.
module tb_lc3_memio;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0;
   logic [15:0] addr = 16'h0000, wdata = 16'h0000;
   logic        kb_valid = 1'b0, dsp_ready = 1'b0;
   logic [7:0]  kb_data = 8'h00;
   int          sel = 1;
   int          n_tests = 0, n_fail = 0;

   logic        me [3], mw [3], kbr [3], dv [3];
   logic [15:0] ma [3], md [3], mdo [3];
   logic [7:0]  dd [3];
   logic        rdy_s;
   logic [15:0] rd_s;
   logic [15:0] sb [$];
   logic [15:0] last_rd [3];

   always #5 clk = ~clk;

   lc3_memio_if #(.DATA_W(16), .ADDR_W(16)) if0 ();
   lc3_memio_if #(.DATA_W(16), .ADDR_W(16)) if1 ();
   lc3_memio_if #(.DATA_W(16), .ADDR_W(16)) if3 ();

   assign if0.cpu_req = req && (sel == 0);
   assign if1.cpu_req = req && (sel == 1);
   assign if3.cpu_req = req && (sel == 2);
   assign {if0.cpu_we, if1.cpu_we, if3.cpu_we} = {3{we}};
   assign if0.cpu_addr = addr;  assign if1.cpu_addr = addr;  assign if3.cpu_addr = addr;
   assign if0.cpu_wdata = wdata; assign if1.cpu_wdata = wdata; assign if3.cpu_wdata = wdata;

   // RAM model: fixed contents, a pure function of the address
   function automatic logic [15:0] ram_fn(input logic [15:0] a);
      return (a == 16'h3000) ? 16'h1234 : ~a;
   endfunction
   assign mdo[0] = ram_fn(ma[0]);
   assign mdo[1] = ram_fn(ma[1]);
   assign mdo[2] = ram_fn(ma[2]);

   function automatic int ws_of(input int s);
      case (s)
         0:       return 0;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   lc3_memio #(.WAIT_STATES(0)) u_ws0 (.clk_i(clk), .rst_ni(rst_n), .cpu(if0),
      .mem_en_o(me[0]), .mem_we_o(mw[0]), .mem_addr_o(ma[0]), .mem_din_o(md[0]), .mem_dout_i(mdo[0]),
      .kb_valid_i(kb_valid), .kb_data_i(kb_data), .kb_ready_o(kbr[0]),
      .dsp_valid_o(dv[0]), .dsp_data_o(dd[0]), .dsp_ready_i(dsp_ready));
   lc3_memio #(.WAIT_STATES(1)) u_ws1 (.clk_i(clk), .rst_ni(rst_n), .cpu(if1),
      .mem_en_o(me[1]), .mem_we_o(mw[1]), .mem_addr_o(ma[1]), .mem_din_o(md[1]), .mem_dout_i(mdo[1]),
      .kb_valid_i(kb_valid), .kb_data_i(kb_data), .kb_ready_o(kbr[1]),
      .dsp_valid_o(dv[1]), .dsp_data_o(dd[1]), .dsp_ready_i(dsp_ready));
   lc3_memio #(.WAIT_STATES(3)) u_ws3 (.clk_i(clk), .rst_ni(rst_n), .cpu(if3),
      .mem_en_o(me[2]), .mem_we_o(mw[2]), .mem_addr_o(ma[2]), .mem_din_o(md[2]), .mem_dout_i(mdo[2]),
      .kb_valid_i(kb_valid), .kb_data_i(kb_data), .kb_ready_o(kbr[2]),
      .dsp_valid_o(dv[2]), .dsp_data_o(dd[2]), .dsp_ready_i(dsp_ready));

   always_comb begin
      case (sel)
         0:       begin rdy_s = if0.cpu_ready; rd_s = if0.cpu_rdata; end
         1:       begin rdy_s = if1.cpu_ready; rd_s = if1.cpu_rdata; end
         default: begin rdy_s = if3.cpu_ready; rd_s = if3.cpu_rdata; end
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: every ready pulse must match the oldest expectation
   always @(posedge clk) begin
      #1;
      if (rst_n && rdy_s) begin
         if (sb.size() == 0) chk("spurious_ready", 32'd1, 32'd0);
         else                chk("rdata", rd_s, sb.pop_front());
      end
   end

   task automatic access(input bit b2b, input bit wr, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] exp_rd);
      int  n = 0, en_n = 0, we_n = 0;
      bit  io = (a[15:9] == 7'h7F);
      int  ws = ws_of(sel);
      if (!b2b) begin
         req = 1'b0;
         @(posedge clk); #1;
      end
      req = 1'b1; we = wr; addr = a; wdata = d;
      if (!wr) last_rd[sel] = exp_rd;
      sb.push_back(last_rd[sel]);
      do begin
         @(posedge clk); #1;
         n++;
         if (me[sel]) en_n++;
         if (mw[sel]) begin
            we_n++;
            chk("mem_addr", ma[sel], a);
            chk("mem_din", md[sel], d);
         end
      end while (!rdy_s && n < 40);
      req = 1'b0;
      chk("latency", n, (b2b ? 1 : 0) + (io ? 1 : ws + 2));
      chk("mem_en_cycles", en_n, io ? 0 : ws + 1);
      chk("mem_we_cycles", we_n, (!io && wr) ? 1 : 0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) last_rd[i] = 16'h0000;
      #12;
      chk("rst_ready", rdy_s, 1'b0);
      chk("rst_mem_en", me[1], 1'b0);
      chk("rst_kb_ready", kbr[1], 1'b1);
      chk("rst_dsp_valid", dv[1], 1'b0);
      @(posedge clk); #1; rst_n = 1'b1;

      // RAM reads and writes across wait-state settings
      sel = 1;
      access(0, 0, 16'h3000, 16'h0000, 16'h1234);
      access(1, 0, 16'h3001, 16'h0000, ram_fn(16'h3001));
      sel = 0;
      access(0, 0, 16'h3000, 16'h0000, 16'h1234);
      access(0, 1, 16'h4000, 16'hBEEF, 16'h0000);
      access(1, 0, 16'h3002, 16'h0000, ram_fn(16'h3002));

      // Keyboard
      sel = 1;
      @(posedge clk); #1; kb_valid = 1'b1; kb_data = 8'h41;
      @(posedge clk); #1; kb_valid = 1'b0; kb_data = 8'h00;
      chk("kb_ready_full", kbr[1], 1'b0);
      access(0, 0, 16'hFE00, 16'h0000, 16'h8000);
      access(0, 0, 16'hFE02, 16'h0000, 16'h0041);
      access(0, 0, 16'hFE00, 16'h0000, 16'h0000);
      chk("kb_ready_empty", kbr[1], 1'b1);

      // Display
      access(0, 1, 16'hFE06, 16'h0058, 16'h0000);
      chk("dsp_valid_set", dv[1], 1'b1);
      chk("dsp_data", dd[1], 8'h58);
      access(0, 0, 16'hFE04, 16'h0000, 16'h0000);
      access(0, 1, 16'hFE06, 16'h0059, 16'h0000);
      chk("dsp_data_kept", dd[1], 8'h58);
      @(posedge clk); #1; dsp_ready = 1'b1;
      @(posedge clk); #1; dsp_ready = 1'b0;
      chk("dsp_valid_clr", dv[1], 1'b0);
      access(0, 0, 16'hFE04, 16'h0000, 16'h8000);

      // Unmapped IO offset and back-to-back IO reads
      access(0, 0, 16'hFFFE, 16'h0000, 16'h0000);
      access(1, 0, 16'hFE04, 16'h0000, 16'h8000);
      access(1, 0, 16'hFFFE, 16'h0000, 16'h0000);

      // Reset in the middle of a 3-wait-state access
      sel = 2;
      access(0, 0, 16'h3000, 16'h0000, 16'h1234);
      @(posedge clk); #1; req = 1'b1; we = 1'b0; addr = 16'h5000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_access_en", me[2], 1'b1);
      #2; rst_n = 1'b0; #1;
      req = 1'b0;
      chk("arst_ready", rdy_s, 1'b0);
      chk("arst_rdata", rd_s, 16'h0000);
      chk("arst_mem_en", me[2], 1'b0);
      chk("arst_mem_we", mw[2], 1'b0);
      chk("arst_mem_addr", ma[2], 16'h0000);
      chk("arst_mem_din", md[2], 16'h0000);
      chk("arst_dsp_valid", dv[1], 1'b0);
      for (int i = 0; i < 3; i++) last_rd[i] = 16'h0000;
      @(posedge clk); #1; rst_n = 1'b1;
      begin
         int rdy_seen = 0;
         for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rdy_s) rdy_seen++;
         end
         chk("no_ready_after_rst", rdy_seen, 0);
      end
      access(0, 0, 16'h3000, 16'h0000, 16'h1234);
      chk("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
